btn_debounce: RTL and testbench



---
 rtl/btn_debounce_bit.sv | 64 ++++++
 rtl/btn_debounce.sv | 30 +++
 tb/tb_btn_debounce.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/btn_debounce_bit.sv
// One button: two-flop synchronizer, then an immediate-response debouncer with a lockout counter.
// The first edge is passed at once; all later input activity is ignored until the counter drains.
module btn_debounce_bit #(
    parameter int LGWAIT = 17
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_btn,
    output logic o_press,
    output logic o_release,
    output logic o_busy
);
    localparam logic [LGWAIT-1:0] RELOAD = '1;
    localparam logic [LGWAIT-1:0] ONE    = LGWAIT'(1);

    typedef enum logic {IDLE, LOCKOUT} state_t;

    logic              sync1, sync2;
    logic [LGWAIT-1:0] cnt, cnt_nxt;
    logic              btn_nxt, press_nxt, release_nxt;
    state_t            state;

    // The state is not stored separately: a nonzero counter is the lockout.
    assign state  = (cnt != '0) ? LOCKOUT : IDLE;
    assign o_busy = (state == LOCKOUT);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            o_btn     <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            sync1     <= i_btn;
            sync2     <= sync1;
            cnt       <= cnt_nxt;
            o_btn     <= btn_nxt;
            o_press   <= press_nxt;
            o_release <= release_nxt;
        end
    end

    always_comb begin
        cnt_nxt     = cnt;
        btn_nxt     = o_btn;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (sync2 != o_btn) begin
                    btn_nxt     = sync2;
                    press_nxt   = sync2;
                    release_nxt = ~sync2;
                    cnt_nxt     = RELOAD;
                end
            end
            LOCKOUT: cnt_nxt = cnt - ONE;
            default: cnt_nxt = '0;
        endcase
    end
endmodule

// File: rtl/btn_debounce.sv
// Debounces NBTN independent push buttons; busy is high while any button is locked out.
// Busy is a pure OR of per-button counter terms, with no extra register stage.
module btn_debounce #(
    parameter int NBTN   = 8,
    parameter int LGWAIT = 17
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [NBTN-1:0] i_btn,
    output logic [NBTN-1:0] o_btn,
    output logic [NBTN-1:0] o_press,
    output logic [NBTN-1:0] o_release,
    output logic            o_busy
);
    logic [NBTN-1:0] busy_v;

    for (genvar i = 0; i < NBTN; i++) begin : g_bit
        btn_debounce_bit #(.LGWAIT(LGWAIT)) u_bit (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_btn     (i_btn[i]),
            .o_btn     (o_btn[i]),
            .o_press   (o_press[i]),
            .o_release (o_release[i]),
            .o_busy    (busy_v[i])
        );
    end

    assign o_busy = |busy_v;
endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with a 16-cycle lockout; per-cycle expectations are queued
// from the documented latencies, then popped and compared each cycle.
module tb_btn_debounce;
    localparam int NBTN   = 8;
    localparam int LGWAIT = 4;

    logic            i_clk = 1'b0;
    logic            i_reset;
    logic [NBTN-1:0] i_btn;
    logic [NBTN-1:0] o_btn, o_press, o_release;
    logic            o_busy;

    typedef struct {
        string           tag;
        logic [NBTN-1:0] btn;
        logic [NBTN-1:0] press;
        logic [NBTN-1:0] rel;
        logic            busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    btn_debounce #(.NBTN(NBTN), .LGWAIT(LGWAIT)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_btn     (i_btn),
        .o_btn     (o_btn),
        .o_press   (o_press),
        .o_release (o_release),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic push(input string tag, input logic [NBTN-1:0] b, input logic [NBTN-1:0] p,
                        input logic [NBTN-1:0] r, input logic bz);
        exp_t e;
        e.tag = tag; e.btn = b; e.press = p; e.rel = r; e.busy = bz;
        exp_q.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL queue_empty observed 0 entries expected 1");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks += 4;
            assert (o_btn === e.btn) else begin
                errors++; $error("FAIL %s o_btn observed %h expected %h", e.tag, o_btn, e.btn);
            end
            assert (o_press === e.press) else begin
                errors++; $error("FAIL %s o_press observed %h expected %h", e.tag, o_press, e.press);
            end
            assert (o_release === e.rel) else begin
                errors++; $error("FAIL %s o_release observed %h expected %h", e.tag, o_release, e.rel);
            end
            assert (o_busy === e.busy) else begin
                errors++; $error("FAIL %s o_busy observed %b expected %b", e.tag, o_busy, e.busy);
            end
        end
    endtask

    // Drive inputs for one cycle, then compare at the following falling edge.
    task automatic tick(input logic [NBTN-1:0] b);
        i_btn = b;
        @(negedge i_clk);
        check();
    endtask

    initial begin
        i_reset = 1'b1;
        i_btn   = '0;

        // Reset state
        @(negedge i_clk);
        push("reset", 8'h00, 8'h00, 8'h00, 1'b0);
        check();
        i_reset = 1'b0;
        for (int k = 1; k <= 5; k++) push("idle", 8'h00, 8'h00, 8'h00, 1'b0);
        for (int k = 1; k <= 5; k++) tick(8'h00);

        // Clean press on button 0: visible at the 3rd edge, busy for 15 cycles
        for (int k = 1; k <= 25; k++)
            push("press0", (k >= 3) ? 8'h01 : 8'h00, (k == 3) ? 8'h01 : 8'h00, 8'h00,
                 (k >= 3 && k <= 17));
        for (int k = 1; k <= 25; k++) tick(8'h01);

        // Bouncing button 2 that settles high: one press, no release
        for (int k = 1; k <= 25; k++)
            push("bounce2", (k >= 3) ? 8'h05 : 8'h01, (k == 3) ? 8'h04 : 8'h00, 8'h00,
                 (k >= 3 && k <= 17));
        for (int k = 1; k <= 25; k++) begin
            logic b2;
            b2 = (k >= 13) ? 1'b1 : (((k - 1) / 3) % 2 == 0);
            tick({5'b0, b2, 2'b01});
        end

        // Short pulse on button 1: release deferred until lockout ends
        for (int k = 1; k <= 40; k++)
            push("pulse1", (k >= 3 && k <= 18) ? 8'h07 : 8'h05, (k == 3) ? 8'h02 : 8'h00,
                 (k == 19) ? 8'h02 : 8'h00, (k >= 3 && k <= 17) || (k >= 19 && k <= 33));
        for (int k = 1; k <= 40; k++) tick((k <= 5) ? 8'h07 : 8'h05);

        // Drop button 0 so it can rise again together with button 7
        for (int k = 1; k <= 20; k++)
            push("rel0", (k >= 3) ? 8'h04 : 8'h05, 8'h00, (k == 3) ? 8'h01 : 8'h00,
                 (k >= 3 && k <= 17));
        for (int k = 1; k <= 20; k++) tick(8'h04);

        // Buttons 0 and 7 rise together; 7 drops during lockout and gets its own window
        for (int k = 1; k <= 40; k++)
            push("dual07", ((k >= 3) ? 8'h05 : 8'h04) | ((k >= 3 && k <= 18) ? 8'h80 : 8'h00),
                 (k == 3) ? 8'h81 : 8'h00, (k == 19) ? 8'h80 : 8'h00,
                 (k >= 3 && k <= 17) || (k >= 19 && k <= 33));
        for (int k = 1; k <= 40; k++) tick((k < 6) ? 8'h85 : 8'h05);

        // Drop button 0, then press it again and reset mid-lockout
        for (int k = 1; k <= 20; k++)
            push("rel0b", (k >= 3) ? 8'h04 : 8'h05, 8'h00, (k == 3) ? 8'h01 : 8'h00,
                 (k >= 3 && k <= 17));
        for (int k = 1; k <= 20; k++) tick(8'h04);
        for (int k = 1; k <= 6; k++)
            push("lock0", (k >= 3) ? 8'h05 : 8'h04, (k == 3) ? 8'h01 : 8'h00, 8'h00, (k >= 3));
        for (int k = 1; k <= 6; k++) tick(8'h05);

        // Async reset between edges clears everything without a clock
        #2 i_reset = 1'b1;
        #1;
        push("async_rst", 8'h00, 8'h00, 8'h00, 1'b0);
        check();
        @(negedge i_clk);
        push("held_rst", 8'h00, 8'h00, 8'h00, 1'b0);
        check();
        i_reset = 1'b0;

        // Held buttons report as fresh presses after reset
        for (int k = 1; k <= 20; k++)
            push("post_rst", (k >= 3) ? 8'h05 : 8'h00, (k == 3) ? 8'h05 : 8'h00, 8'h00,
                 (k >= 3 && k <= 17));
        for (int k = 1; k <= 20; k++) tick(8'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
